// File: rtl/audio_level_meter.sv
// Windowed peak-magnitude meter feeding the bar display. LEVEL_METER_DECAY_EN adds peak-hold with slow decay.
// Latency: peak/level/vol/update change 1 clk after the last sample of a window is accepted.
// Backpressure: none; every sample_valid cycle is consumed, and idle cycles leave all state unchanged.
module audio_level_meter #(
   parameter int unsigned WINDOW        = 1024,
   parameter logic [23:0] THRESH_BASE   = 24'h000400,
   parameter int unsigned THRESH_SHIFT  = 2,
   parameter int unsigned DECAY_WINDOWS = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [23:0] sample_in,
   input  logic        sample_valid,
   output logic [23:0] peak,
   output logic [2:0]  level,
   output logic [5:0]  vol,
   output logic        update
);

   localparam int unsigned CNT_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

   logic [23:0]      acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [23:0]      peak_q, peak_d;
   logic [2:0]       level_q, level_d;
   logic             update_q, update_d;

   logic [23:0] mag;
   logic [23:0] win_peak;
   logic        win_end;
   logic [5:0]  hit;
   logic [2:0]  raw_level;
   logic [2:0]  next_level;

   // The most negative sample has no positive twin in 24 bits, so it clips.
   always_comb begin
      if (!sample_in[23]) begin
         mag = sample_in;
      end else if (sample_in == 24'h800000) begin
         mag = 24'h7FFFFF;
      end else begin
         mag = -sample_in;
      end
   end

   assign win_peak = (mag > acc_q) ? mag : acc_q;
   assign win_end  = sample_valid && (cnt_q == CNT_LAST);

   for (genvar k = 0; k < 6; k++) begin : g_thr
      localparam int unsigned SH  = int'(k) * THRESH_SHIFT;
      localparam logic [63:0] RAW = (SH >= 32) ? 64'h1_0000_0000 : (64'(THRESH_BASE) << SH);
      localparam logic [23:0] THR = (THRESH_BASE == 24'h0)  ? 24'h0 :
                                    (RAW > 64'hFF_FFFF)     ? 24'hFF_FFFF : RAW[23:0];
      assign hit[k] = (win_peak >= THR);
   end

   always_comb begin
      raw_level = 3'd0;
      for (int k = 0; k < 6; k++) begin
         if (hit[k]) begin
            raw_level = raw_level + 3'd1;
         end
      end
   end

`ifdef LEVEL_METER_DECAY_EN
   localparam int unsigned DW = (DECAY_WINDOWS > 2) ? $clog2(DECAY_WINDOWS) : 1;
   localparam logic [DW-1:0] DECAY_LAST = DW'(DECAY_WINDOWS - 1);

   logic [DW-1:0] decay_cnt_q, decay_cnt_d;

   // Rises track immediately; a fall steps down once per DECAY_WINDOWS quieter windows.
   always_comb begin
      next_level  = level_q;
      decay_cnt_d = decay_cnt_q;
      if (win_end) begin
         if (raw_level >= level_q) begin
            next_level  = raw_level;
            decay_cnt_d = '0;
         end else if (decay_cnt_q == DECAY_LAST) begin
            next_level  = level_q - 3'd1;
            decay_cnt_d = '0;
         end else begin
            decay_cnt_d = decay_cnt_q + DW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         decay_cnt_q <= '0;
      end else begin
         decay_cnt_q <= decay_cnt_d;
      end
   end
`else
   assign next_level = raw_level;
`endif

   always_comb begin
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      peak_d   = peak_q;
      level_d  = level_q;
      update_d = 1'b0;
      if (sample_valid) begin
         if (win_end) begin
            acc_d    = '0;
            cnt_d    = '0;
            peak_d   = win_peak;
            level_d  = next_level;
            update_d = 1'b1;
         end else begin
            acc_d = win_peak;
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= '0;
         cnt_q    <= '0;
         peak_q   <= '0;
         level_q  <= '0;
         update_q <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         peak_q   <= peak_d;
         level_q  <= level_d;
         update_q <= update_d;
      end
   end

   assign peak   = peak_q;
   assign level  = level_q;
   assign vol    = (level_q == 3'd0) ? 6'b0 : (6'b000001 << (level_q - 3'd1));
   assign update = update_q;

endmodule
